// File: rtl/gate_alu_pkg.sv
// Shared types for the gate ALU: op codes and controller states.
package gate_alu_pkg;

  typedef enum logic [2:0] {
    OP_OR     = 3'd0,
    OP_AND    = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/gate_alu_func.sv
// Combinational bitwise evaluator z = f(op, x, y); x is the primary operand.
module gate_func
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] z_o
);

  always_comb begin
    z_o = x_i;
    case (op_i)
      OP_OR:    z_o = x_i | y_i;
      OP_AND:   z_o = x_i & y_i;
      OP_NAND:  z_o = ~(x_i & y_i);
      OP_NOR:   z_o = ~(x_i | y_i);
      OP_XOR:   z_o = x_i ^ y_i;
      OP_XNOR:  z_o = ~(x_i ^ y_i);
      OP_NOT_A: z_o = ~x_i;
      default:  z_o = x_i;
    endcase
  end

endmodule

// File: rtl/gate_alu.sv
// Handshaked bitwise ALU: single-shot or burst-accumulated results, 1-cycle latency.
// A pending result blocks new beats unless the consumer takes it in the same cycle.
module gate_alu
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             parity
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] count_q;

  logic             in_acc;
  logic             accept;
  logic             finish;
  logic             start;
  logic [WIDTH-1:0] x_mux;
  logic [WIDTH-1:0] y_mux;
  logic [WIDTH-1:0] val_d;
  logic [CNT_W-1:0] cnt_d;

  assign in_acc   = (state_q == ACC);
  assign in_ready = !rst && (state_q != HOLD) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign finish   = accept && (in_acc ? last : (!acc_en || last));
  assign start    = accept && !in_acc && acc_en && !last;

  // Mid-burst the accumulator becomes the primary operand and a the secondary.
  assign x_mux = in_acc ? acc_q : a;
  assign y_mux = in_acc ? a : b;
  assign cnt_d = !in_acc ? CNT_W'(1) :
                 (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  gate_func #(.WIDTH(WIDTH)) u_func (
    .op_i (op_e'(op)),
    .x_i  (x_mux),
    .y_i  (y_mux),
    .z_o  (val_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      count_q     <= '0;
    end else begin
      if (finish) begin
        result_q    <= val_d;
        count_q     <= cnt_d;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept && !finish) begin
        acc_q <= val_d;
        cnt_q <= cnt_d;
      end

      case (state_q)
        IDLE: begin
          if (start)
            state_q <= ACC;
          else if (!finish && out_valid_q && !out_ready)
            state_q <= HOLD;
        end
        ACC: begin
          if (finish)
            state_q <= IDLE;
        end
        HOLD: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign count     = count_q;
  assign zero      = (result_q == '0);
  assign parity    = ^result_q;

endmodule

// File: tb/tb_gate_alu.sv
// Bench for gate_alu: directed scenarios plus a randomized scoreboard run.
module tb_gate_alu;

  logic       clk;
  logic       rst, in_valid, in_ready, acc_en, last, out_valid, out_ready, zero, parity;
  logic [2:0] op;
  logic [7:0] a, b, result;
  logic [3:0] count;

  logic       rst2, in_valid2, in_ready2, acc_en2, last2, out_valid2, out_ready2, zero2, parity2;
  logic [2:0] op2;
  logic [7:0] a2, b2, result2;
  logic [1:0] count2;

  int checks = 0;
  int passes = 0;

  gate_alu #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .acc_en(acc_en), .last(last), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .count(count), .zero(zero), .parity(parity)
  );

  gate_alu #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2),
    .a(a2), .b(b2), .acc_en(acc_en2), .last(last2), .out_valid(out_valid2),
    .out_ready(out_ready2), .result(result2), .count(count2), .zero(zero2), .parity(parity2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_f(input int opc, input logic [7:0] x, input logic [7:0] y);
    case (opc)
      0: return x | y;
      1: return x & y;
      2: return ~(x & y);
      3: return ~(x | y);
      4: return x ^ y;
      5: return ~(x ^ y);
      6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic ae, input logic l);
    in_valid = v; op = o; a = aa; b = bb; acc_en = ae; last = l;
  endtask

  task automatic test_reset();
    rst = 1; out_ready = 0; drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got=%0b want=0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", out_valid); else passes++;
    checks++; if (result !== 8'h00) $display("FAIL reset_result got=%h want=00", result); else passes++;
    checks++; if (count !== 4'd0) $display("FAIL reset_count got=%0d want=0", count); else passes++;
    checks++; if (zero !== 1'b1 || parity !== 1'b0) $display("FAIL reset_flags got z=%0b p=%0b want z=1 p=0", zero, parity); else passes++;
    rst = 0; #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%0b want=1", in_ready); else passes++;
  endtask

  task automatic test_single();
    @(negedge clk);
    out_ready = 0; drive(1, 3'd4, 8'hF0, 8'h3C, 0, 0);
    @(negedge clk);
    in_valid = 0; #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got=%0b want=1", out_valid); else passes++;
    checks++; if (result !== 8'hCC) $display("FAIL single_result got=%h want=cc", result); else passes++;
    checks++; if (count !== 4'd1) $display("FAIL single_count got=%0d want=1", count); else passes++;
    checks++; if (zero !== 1'b0 || parity !== 1'b0) $display("FAIL single_flags got z=%0b p=%0b want z=0 p=0", zero, parity); else passes++;
  endtask

  task automatic test_backpressure();
    out_ready = 0; drive(1, 3'd1, 8'hFF, 8'h0F, 0, 0); #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_blocked got=%0b want=0", in_ready); else passes++;
    checks++; if (result !== 8'hCC) $display("FAIL bp_result_stable got=%h want=cc", result); else passes++;
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_released got=%0b want=1", in_ready); else passes++;
    @(negedge clk);
    in_valid = 0; #1;
    checks++; if (out_valid !== 1'b1 || result !== 8'h0F) $display("FAIL bp_back_to_back got v=%0b r=%h want v=1 r=0f", out_valid, result); else passes++;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_retire got=%0b want=0", out_valid); else passes++;
  endtask

  task automatic test_hold();
    out_ready = 0; drive(1, 3'd0, 8'h55, 8'h00, 0, 0);
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (in_ready !== 1'b0 || result !== 8'h55) $display("FAIL hold_stall_%0d got rdy=%0b r=%h want rdy=0 r=55", i, in_ready, result); else passes++;
    end
    out_ready = 1; drive(1, 3'd7, 8'hAA, 8'h00, 0, 0); #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL hold_release_rdy got=%0b want=0", in_ready); else passes++;
    @(negedge clk);
    in_valid = 0; #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL hold_retire got=%0b want=0", out_valid); else passes++;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL hold_beat_dropped got=%0b want=0", out_valid); else passes++;
  endtask

  task automatic test_accumulate();
    out_ready = 1; drive(1, 3'd0, 8'h01, 8'h02, 1, 0);
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL acc_beat1_quiet got=%0b want=0", out_valid); else passes++;
    drive(1, 3'd0, 8'h04, 8'hFF, 1, 0);
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL acc_beat2_quiet got=%0b want=0", out_valid); else passes++;
    drive(1, 3'd0, 8'h08, 8'hFF, 0, 1);
    @(negedge clk);
    in_valid = 0; #1;
    checks++; if (out_valid !== 1'b1 || result !== 8'h0F) $display("FAIL acc_result got v=%0b r=%h want v=1 r=0f", out_valid, result); else passes++;
    checks++; if (count !== 4'd3 || parity !== 1'b0) $display("FAIL acc_count_parity got c=%0d p=%0b want c=3 p=0", count, parity); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1; drive(1, 3'd4, 8'h3A, 8'h5C, 1, 0);
    @(negedge clk);
    drive(1, 3'd4, 8'h77, 8'h00, 1, 0);
    @(negedge clk);
    in_valid = 0; rst = 1; #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL rmb_in_ready got=%0b want=0", in_ready); else passes++;
    @(negedge clk);
    rst = 0; #1;
    checks++; if (out_valid !== 1'b0 || count !== 4'd0 || result !== 8'h00) $display("FAIL rmb_cleared got v=%0b c=%0d r=%h want v=0 c=0 r=00", out_valid, count, result); else passes++;
    drive(1, 3'd7, 8'h81, 8'h5A, 0, 0);
    @(negedge clk);
    in_valid = 0; #1;
    checks++; if (out_valid !== 1'b1 || result !== 8'h81) $display("FAIL rmb_pass got v=%0b r=%h want v=1 r=81", out_valid, result); else passes++;
    checks++; if (count !== 4'd1 || parity !== 1'b0) $display("FAIL rmb_count_parity got c=%0d p=%0b want c=1 p=0", count, parity); else passes++;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst2 = 0; out_ready2 = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1; op2 = 3'd1; a2 = 8'hFF; b2 = 8'hFF; acc_en2 = 1; last2 = (i == 4);
      @(negedge clk);
    end
    in_valid2 = 0; #1;
    checks++; if (out_valid2 !== 1'b1 || result2 !== 8'hFF) $display("FAIL sat_result got v=%0b r=%h want v=1 r=ff", out_valid2, result2); else passes++;
    checks++; if (count2 !== 2'd3 || parity2 !== 1'b0) $display("FAIL sat_count_parity got c=%0d p=%0b want c=3 p=0", count2, parity2); else passes++;
  endtask

  task automatic test_random();
    logic [7:0] exp_res[$];
    int         exp_cnt[$];
    logic       burst = 0;
    logic [7:0] macc = 0;
    int         mcnt = 0;
    logic       prev_stall = 0;
    logic [7:0] prev_res = 0;
    logic       exp_rdy;
    logic [7:0] v;
    logic [7:0] er;
    int         ec;
    in_valid = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    for (int cyc = 0; cyc < 3020; cyc++) begin
      @(negedge clk);
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      if (cyc < 3000) begin
        in_valid = ($urandom_range(0, 3) != 0); acc_en = 1'($urandom_range(0, 1));
        last = ($urandom_range(0, 2) == 0); out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = burst; acc_en = 1; last = 1; out_ready = 1;
      end
      #1;
      exp_rdy = !out_valid || (out_ready && !prev_stall);
      checks++; if (in_ready !== exp_rdy) $display("FAIL rnd_in_ready cyc=%0d got=%0b want=%0b", cyc, in_ready, exp_rdy); else passes++;
      if (prev_stall) begin
        checks++; if (result !== prev_res) $display("FAIL rnd_stable cyc=%0d got=%h want=%h", cyc, result, prev_res); else passes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_res.size() == 0) $display("FAIL rnd_spurious cyc=%0d got r=%h want no result", cyc, result);
        else begin
          er = exp_res.pop_front(); ec = exp_cnt.pop_front();
          if (result !== er || count !== 4'(ec) || zero !== (er == 0) || parity !== ^er)
            $display("FAIL rnd_result cyc=%0d got r=%h c=%0d z=%0b p=%0b want r=%h c=%0d z=%0b p=%0b",
                     cyc, result, count, zero, parity, er, ec, (er == 0), ^er);
          else passes++;
        end
      end
      if (in_valid && in_ready) begin
        if (!burst) begin
          v = ref_f(int'(op), a, b);
          if (acc_en && !last) begin burst = 1; macc = v; mcnt = 1; end
          else begin exp_res.push_back(v); exp_cnt.push_back(1); end
        end else begin
          macc = ref_f(int'(op), macc, a);
          mcnt = (mcnt < 15) ? mcnt + 1 : 15;
          if (last) begin exp_res.push_back(macc); exp_cnt.push_back(mcnt); burst = 0; end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res = result;
    end
    checks++; if (exp_res.size() != 0 || burst) $display("FAIL rnd_drain got pending=%0d burst=%0b want 0 0", exp_res.size(), burst); else passes++;
  endtask

  initial begin
    clk = 0; rst = 1; out_ready = 0; drive(0, 0, 0, 0, 0, 0);
    rst2 = 1; in_valid2 = 0; op2 = 0; a2 = 0; b2 = 0; acc_en2 = 0; last2 = 0; out_ready2 = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_hold();
    test_accumulate();
    test_reset_mid_burst();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
